// File: rtl/store_merge_unit_pkg.sv
// Shared definitions for the store merge unit.
//   SOP_* : store/load size codes, shared with the load extender
//   state_e : control FSM states
//   store_illegal() : size/alignment rejection rule applied at accept
package store_merge_unit_pkg;

  localparam logic [1:0] SOP_WORD = 2'b00;
  localparam logic [1:0] SOP_HALF = 2'b01;
  localparam logic [1:0] SOP_BYTE = 2'b10;
  localparam logic [1:0] SOP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrite
  } state_e;

  // Reserved size, misaligned word, or half straddling a half-word boundary.
  function automatic logic store_illegal(logic [1:0] sop, logic [1:0] lane);
    return (sop == SOP_RSVD) ||
           ((sop == SOP_WORD) && (lane != 2'b00)) ||
           ((sop == SOP_HALF) && lane[0]);
  endfunction

endpackage

// File: rtl/store_merge_unit_if.sv
// Request and memory bus of the store merge unit.
//   req_*        : store request handshake from the datapath store stage
//   done / err   : single-cycle completion / rejection pulses
//   mem_*        : word-wide data memory read and write ports
// Modports: master = the store merge unit, slave = datapath plus memory.
interface store_merge_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_sop;
  logic              done;
  logic              err;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;

  modport master (
    input  req_valid, req_addr, req_data, req_sop, mem_rdata, mem_rvalid,
    output req_ready, done, err, mem_rd_en, mem_addr, mem_wr_en, mem_wdata
  );

  modport slave (
    output req_valid, req_addr, req_data, req_sop, mem_rdata, mem_rvalid,
    input  req_ready, done, err, mem_rd_en, mem_addr, mem_wr_en, mem_wdata
  );
endinterface

// File: rtl/store_lane_merge.sv
// Combinational lane insertion for sub-word stores.
//   rdata_i : word read back from memory
//   data_i  : right-justified store data
//   lane_i  : byte offset within the word (addr[1:0])
//   sop_i   : store size code
//   wdata_o : word to write back
module store_lane_merge
  import store_merge_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  sop_i,
  output logic [31:0] wdata_o
);

  always_comb begin
    wdata_o = rdata_i;
    case (sop_i)
      SOP_BYTE: wdata_o[8*lane_i +: 8]     = data_i[7:0];
      SOP_HALF: wdata_o[16*lane_i[1] +: 16] = data_i[15:0];
      default:  wdata_o = data_i;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store merge unit: turns word/half/byte store requests into aligned 32-bit memory
// writes, doing read-modify-write for sub-word stores.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request handshake, done/err pulses and memory ports (master side)
// Parameters: ADDR_W byte-address width, RD_TIMEOUT max cycles waiting for read data.
module store_merge_unit
  import store_merge_unit_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RD_TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst_n,
  store_merge_unit_if.master bus
);

  localparam int unsigned CntW = $clog2(RD_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        sop_q, sop_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merged;

  store_lane_merge u_lane_merge (
    .rdata_i (bus.mem_rdata),
    .data_i  (data_q),
    .lane_i  (lane_q),
    .sop_i   (sop_q),
    .wdata_o (merged)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    addr_d  = addr_q;
    lane_d  = lane_q;
    data_d  = data_q;
    sop_d   = sop_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        // err_q high means the rejection pulse is still showing; not ready yet.
        if (bus.req_valid && !err_q) begin
          if (store_illegal(bus.req_sop, bus.req_addr[1:0])) begin
            err_d = 1'b1;
          end else begin
            addr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
            lane_d = bus.req_addr[1:0];
            data_d = bus.req_data;
            sop_d  = bus.req_sop;
            if (bus.req_sop == SOP_WORD) begin
              wdata_d = bus.req_data;
              state_d = StWrite;
            end else begin
              state_d = StRdReq;
            end
          end
        end
      end
      StRdReq: begin
        cnt_d   = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (bus.mem_rvalid) begin
          wdata_d = merged;
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntW'(RD_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      lane_q  <= 2'b00;
      data_q  <= '0;
      sop_q   <= SOP_WORD;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle) && !err_q;
  assign bus.err       = err_q;
  assign bus.mem_rd_en = (state_q == StRdReq);
  assign bus.mem_wr_en = (state_q == StWrite);
  assign bus.done      = (state_q == StWrite);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule
